// File: rtl/daq_framer.sv
// Drains the DAQ word ring and length FIFO and emits one big-endian byte frame per packet.
// Optional CRC-16/CCITT-FALSE trailer is enabled by defining DAQ_FRAMER_CRC_EN.
module daq_framer #(
    parameter int          MAC_PACKET_BITS = 11,
    parameter logic [7:0]  FRAME_TYPE      = 8'hDA
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                systime,
    input  logic [MAC_PACKET_BITS-1:0] daq_len,
    input  logic                       daq_len_ready,
    output logic                       daq_len_rd_en,
    input  logic [31:0]                daq_data,
    output logic                       daq_data_rd_en,
    output logic [7:0]                 mac_tx_data,
    output logic                       mac_tx_valid,
    output logic                       mac_tx_last,
    input  logic                       mac_tx_ready,
    output logic [15:0]                frames_sent
);

`ifdef DAQ_FRAMER_CRC_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, CRC} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    state_t                     state, state_next;
    logic [2:0]                 idx, idx_next;
    logic [MAC_PACKET_BITS-1:0] len_q, words_left;
    logic [31:0]                time_q, word_q;
    logic [7:0]                 seq;
    logic [15:0]                frames_cnt;
    logic [15:0]                len16;
    logic                       end_pos, fetch, payload_end, frame_done;

    assign len16       = 16'(len_q);
    assign frames_sent = frames_cnt;

    function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [7:0] sq,
                                            input logic [15:0] ln, input logic [31:0] tm);
        case (i)
            3'd0:    hdr_byte = FRAME_TYPE;
            3'd1:    hdr_byte = sq;
            3'd2:    hdr_byte = ln[15:8];
            3'd3:    hdr_byte = ln[7:0];
            3'd4:    hdr_byte = tm[31:24];
            3'd5:    hdr_byte = tm[23:16];
            3'd6:    hdr_byte = tm[15:8];
            default: hdr_byte = tm[7:0];
        endcase
    endfunction

    function automatic logic [7:0] word_byte(input logic [1:0] i, input logic [31:0] w);
        case (i)
            2'd0:    word_byte = w[31:24];
            2'd1:    word_byte = w[23:16];
            2'd2:    word_byte = w[15:8];
            default: word_byte = w[7:0];
        endcase
    endfunction

`ifdef DAQ_FRAMER_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        mac_tx_valid   = 1'b0;
        mac_tx_data    = 8'h00;
        mac_tx_last    = 1'b0;
        daq_len_rd_en  = 1'b0;
        fetch          = 1'b0;
        payload_end    = 1'b0;
        frame_done     = 1'b0;
        end_pos        = 1'b0;

        case (state)
            IDLE: begin
                if (daq_len_ready) begin
                    daq_len_rd_en = 1'b1;
                    state_next    = HDR;
                    idx_next      = 3'd0;
                end
            end
            HDR: begin
                mac_tx_valid = 1'b1;
                mac_tx_data  = hdr_byte(idx, seq, len16, time_q);
                end_pos      = (idx == 3'd7);
                if (mac_tx_ready && !end_pos) idx_next = idx + 3'd1;
            end
            PAY: begin
                mac_tx_valid = 1'b1;
                mac_tx_data  = word_byte(idx[1:0], word_q);
                end_pos      = (idx[1:0] == 2'd3);
                if (mac_tx_ready && !end_pos) idx_next = idx + 3'd1;
            end
`ifdef DAQ_FRAMER_CRC_EN
            CRC: begin
                mac_tx_valid = 1'b1;
                mac_tx_data  = idx[0] ? crc[7:0] : crc[15:8];
                mac_tx_last  = idx[0];
                if (mac_tx_ready) begin
                    if (idx[0]) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next = 3'd1;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Boundary of a header or word: fetch the next word, or close the payload.
        if (end_pos && mac_tx_ready) begin
            if (words_left != '0) begin
                fetch      = 1'b1;
                state_next = PAY;
                idx_next   = 3'd0;
            end else begin
                payload_end = 1'b1;
            end
        end

`ifdef DAQ_FRAMER_CRC_EN
        if (payload_end) begin
            state_next = CRC;
            idx_next   = 3'd0;
        end
`else
        mac_tx_last = end_pos && (words_left == '0);
        if (payload_end) begin
            frame_done = 1'b1;
            state_next = IDLE;
        end
`endif

        // A pop during reset would be lost along with the aborted frame.
        if (rst) begin
            daq_len_rd_en = 1'b0;
            fetch         = 1'b0;
        end
        daq_data_rd_en = fetch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            words_left <= '0;
            seq        <= 8'h00;
            frames_cnt <= 16'h0000;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (daq_len_rd_en)  words_left <= daq_len;
            else if (fetch)     words_left <= words_left - 1'b1;
            if (frame_done) begin
                seq        <= seq + 8'h01;
                frames_cnt <= frames_cnt + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (daq_len_rd_en) begin
            len_q  <= daq_len;
            time_q <= systime;
        end
        if (fetch) word_q <= daq_data;
`ifdef DAQ_FRAMER_CRC_EN
        if (daq_len_rd_en)
            crc <= 16'hFFFF;
        else if (mac_tx_valid && mac_tx_ready && state != CRC)
            crc <= crc16_upd(crc, mac_tx_data);
`endif
    end

endmodule

// File: tb/tb_daq_framer.sv
// Directed bench for daq_framer: FIFO/ring responders, byte monitor and stream comparison.
// Define DAQ_FRAMER_CRC_EN for both RTL and bench to exercise the CRC trailer.
module tb_daq_framer;
    localparam int LB = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   systime = 32'h0;
    logic [LB-1:0] daq_len = '0;
    logic          daq_len_ready = 1'b0;
    logic          daq_len_rd_en;
    logic [31:0]   daq_data = 32'h0;
    logic          daq_data_rd_en;
    logic [7:0]    mac_tx_data;
    logic          mac_tx_valid;
    logic          mac_tx_last;
    logic          mac_tx_ready = 1'b1;
    logic [15:0]   frames_sent;

    daq_framer #(.MAC_PACKET_BITS(LB), .FRAME_TYPE(8'hDA)) dut (
        .clk(clk), .rst(rst), .systime(systime),
        .daq_len(daq_len), .daq_len_ready(daq_len_ready), .daq_len_rd_en(daq_len_rd_en),
        .daq_data(daq_data), .daq_data_rd_en(daq_data_rd_en),
        .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid), .mac_tx_last(mac_tx_last),
        .mac_tx_ready(mac_tx_ready), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          len_fifo[$];
    logic [31:0] word_fifo[$];
    logic [7:0]  cap[$];
    logic [7:0]  expb[$];
    logic        cap_last[$];
    logic        exp_last[$];
    logic [31:0] tw[0:3];
    int          len_pops = 0;
    int          data_pops = 0;
    logic        pend_len = 1'b0;
    logic        pend_data = 1'b0;
    logic        rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // FIFO/ring responders and byte monitor, all on the falling edge.
    always @(negedge clk) begin
        int dummy;
        logic [31:0] wdummy;
        if (pend_len) begin
            len_pops++;
            if (len_fifo.size() != 0) dummy = len_fifo.pop_front();
        end
        if (pend_data) begin
            data_pops++;
            if (word_fifo.size() != 0) wdummy = word_fifo.pop_front();
        end
        daq_len_ready = (len_fifo.size() != 0);
        daq_len       = (len_fifo.size() != 0) ? LB'(len_fifo[0]) : '0;
        daq_data      = (word_fifo.size() != 0) ? word_fifo[0] : 32'h0;
        mac_tx_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (prev_stall) begin
            check("hold_valid", 64'(mac_tx_valid), 64'd1);
            check("hold_data", 64'(mac_tx_data), 64'(prev_data));
        end
        if (mac_tx_valid && mac_tx_ready && !rst) begin
            cap.push_back(mac_tx_data);
            cap_last.push_back(mac_tx_last);
        end
        prev_stall = mac_tx_valid && !mac_tx_ready && !rst;
        prev_data  = mac_tx_data;
        pend_len   = daq_len_rd_en;
        pend_data  = daq_data_rd_en;
    end

    task automatic queue_frame(input int len, input logic [7:0] sq);
        logic [15:0] l16;
        logic [31:0] w;
        logic [7:0]  b;
`ifdef DAQ_FRAMER_CRC_EN
        logic [15:0] c;
        c = 16'hFFFF;
`endif
        l16 = 16'(len);
        for (int i = 0; i < 8 + 4 * len; i++) begin
            case (i)
                0: b = 8'hDA;
                1: b = sq;
                2: b = l16[15:8];
                3: b = l16[7:0];
                4: b = systime[31:24];
                5: b = systime[23:16];
                6: b = systime[15:8];
                7: b = systime[7:0];
                default: begin
                    w = tw[(i - 8) / 4];
                    b = w[31 - 8 * ((i - 8) % 4) -: 8];
                end
            endcase
            expb.push_back(b);
            exp_last.push_back(1'b0);
`ifdef DAQ_FRAMER_CRC_EN
            c = crc16_step(c, b);
`endif
        end
`ifdef DAQ_FRAMER_CRC_EN
        expb.push_back(c[15:8]); exp_last.push_back(1'b0);
        expb.push_back(c[7:0]);  exp_last.push_back(1'b0);
`endif
        exp_last[exp_last.size() - 1] = 1'b1;
        for (int i = 0; i < len; i++) word_fifo.push_back(tw[i]);
        len_fifo.push_back(len);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (frames_sent != 16'(n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(frames_sent), 64'(16'(n)));
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 64'(cap.size()), 64'(expb.size()));
        for (int i = 0; i < cap.size() && i < expb.size(); i++) begin
            if (cap[i] !== expb[i] || cap_last[i] !== exp_last[i]) begin
                check($sformatf("%s_byte%0d", tag, i), 64'(cap[i]), 64'(expb[i]));
                check($sformatf("%s_last%0d", tag, i), 64'(cap_last[i]), 64'(exp_last[i]));
            end else begin
                n_checks += 2;
                n_pass   += 2;
            end
        end
        cap.delete(); cap_last.delete(); expb.delete(); exp_last.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(mac_tx_valid), 64'd0);
        check({tag, "_data"}, 64'(mac_tx_data), 64'd0);
        check({tag, "_last"}, 64'(mac_tx_last), 64'd0);
        check({tag, "_frames"}, 64'(frames_sent), 64'd0);
        check({tag, "_lenrd"}, 64'(daq_len_rd_en), 64'd0);
        check({tag, "_datrd"}, 64'(daq_data_rd_en), 64'd0);
    endtask

    initial begin
        logic [7:0] a_exp[16];
        logic [7:0] s9[9];
        logic [15:0] c9;
        int lp, dp;

        a_exp = '{8'hDA, 8'h00, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE,
                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c9 = 16'hFFFF;
        for (int i = 0; i < 9; i++) c9 = crc16_step(c9, s9[i]);
        check("crc_model_123456789", 64'(c9), 64'h29B1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check_idle_outputs("reset");

        // L=2, ready always high
        @(negedge clk);
        systime = 32'hCAFEBABE;
        tw[0] = 32'h11223344; tw[1] = 32'h55667788;
        lp = len_pops; dp = data_pops;
        queue_frame(2, 8'h00);
        wait_frames("a_done", 1, 200);
        for (int i = 0; i < 16; i++)
            if (i < cap.size()) check($sformatf("a_lit%0d", i), 64'(cap[i]), 64'(a_exp[i]));
`ifndef DAQ_FRAMER_CRC_EN
        if (cap_last.size() == 16) check("a_last_on_88", 64'(cap_last[15]), 64'd1);
`endif
        compare_stream("a");
        repeat (2) @(negedge clk);
        check("a_len_pops", 64'(len_pops - lp), 64'd1);
        check("a_data_pops", 64'(data_pops - dp), 64'd2);

        // L=0 empty grant
        systime = 32'h01020304;
        dp = data_pops;
        queue_frame(0, 8'h01);
        wait_frames("b_done", 2, 200);
`ifndef DAQ_FRAMER_CRC_EN
        check("b_bytes", 64'(cap.size()), 64'd8);
        if (cap.size() == 8) begin
            check("b_seq", 64'(cap[1]), 64'h01);
            check("b_last8", 64'(cap_last[7]), 64'd1);
        end
`endif
        compare_stream("b");
        repeat (2) @(negedge clk);
        check("b_data_pops", 64'(data_pops - dp), 64'd0);

        // Random backpressure
        rand_ready = 1'b1;
        systime = 32'h89ABCDEF;
        tw[0] = 32'hA1B2C3D4; tw[1] = 32'h00FF00FF; tw[2] = 32'hDEADBEEF;
        queue_frame(3, 8'h02);
        wait_frames("c_done", 3, 1000);
        compare_stream("c");
        rand_ready = 1'b0;

        // 257 back-to-back L=1 frames from reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("d_reset_frames", 64'(frames_sent), 64'd0);
        systime = 32'h0BADF00D;
        for (int k = 0; k < 257; k++) begin
            tw[0] = (k == 5) ? 32'hFE000005 : (32'h0A000000 + 32'(k));
            queue_frame(1, 8'(k));
        end
        wait_frames("d_done", 257, 20000);
        compare_stream("d");

        // Reset in the middle of word 2
        systime = 32'h13579BDF;
        tw[0] = 32'h01010101; tw[1] = 32'h02020202; tw[2] = 32'h03030303;
        dp = data_pops;
        queue_frame(3, 8'h01);
        for (int k = 0; k < 200 && data_pops - dp < 2; k++) @(negedge clk);
        check("e_two_pops", 64'(data_pops - dp), 64'd2);
        repeat (2) @(negedge clk);
        #2;
        check("e_mid_valid", 64'(mac_tx_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        len_fifo.delete(); word_fifo.delete();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_idle_outputs("e_rst");
        cap.delete(); cap_last.delete(); expb.delete(); exp_last.delete();
        repeat (2) @(negedge clk);
        lp = len_pops; dp = data_pops;
        repeat (10) @(negedge clk);
        check("e_no_len_pops", 64'(len_pops - lp), 64'd0);
        check("e_no_data_pops", 64'(data_pops - dp), 64'd0);
        check("e_idle_valid", 64'(mac_tx_valid), 64'd0);
        systime = 32'h2468ACE0;
        queue_frame(0, 8'h00);
        wait_frames("e_after", 1, 200);
        compare_stream("e");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
